// File: rtl/edge_det_pkg.sv
// Shared definitions for the edge/event detector.
// Holds the edge_sel encodings, default parameter values and the
// helper that decides whether a filtered edge counts as an event.
package edge_det_pkg;

  localparam int unsigned CH_DEF          = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned FILT_W_DEF      = 4;
  localparam int unsigned CNT_W_DEF       = 8;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_RISE = 2'b01,
    SEL_FALL = 2'b10,
    SEL_BOTH = 2'b11
  } edge_sel_e;

  // True when a rise/fall pulse matches the edge selection.
  function automatic logic sel_qualifies(logic [1:0] sel, logic rise, logic fall);
    logic q;
    q = 1'b0;
    case (sel)
      SEL_RISE: q = rise;
      SEL_FALL: q = fall;
      SEL_BOTH: q = rise | fall;
      default:  q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One detector channel: synchroniser, glitch filter, edge pulses,
// sticky event flag and saturating event counter.
// Ports:
//   clk_in, rst_n   clock / async active-low reset
//   raw_i           asynchronous raw input
//   edge_sel_i      edge qualification (none/rise/fall/both)
//   filt_len_i      stable-cycle requirement L (sampled live)
//   clr_i           clears flag and counter (a same-cycle event wins)
//   rise_o, fall_o  one-cycle filtered edge pulses
//   flag_o, cnt_o   sticky event flag and event count
module edge_chan
  import edge_det_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned FILT_W      = FILT_W_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              raw_i,
  input  logic [1:0]        edge_sel_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic              clr_i,
  output logic              rise_o,
  output logic              fall_o,
  output logic              flag_o,
  output logic [CNT_W-1:0]  cnt_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   filt_q, filt_d;
  logic [FILT_W-1:0]      fcnt_q, fcnt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   flag_q, flag_d;
  logic [CNT_W-1:0]       ecnt_q, ecnt_d;
  logic                   s;
  logic                   qual;

  assign s    = sync_q[SYNC_STAGES-1];
  assign qual = sel_qualifies(edge_sel_i, rise_q, fall_q);

  // State registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      fcnt_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      flag_q <= 1'b0;
      ecnt_q <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      flag_q <= flag_d;
      ecnt_q <= ecnt_d;
    end
  end

  // Next-state: filter, edge pulses, flag and counter.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    flag_d = flag_q;
    ecnt_d = ecnt_q;

    // >= (not ==) so a mid-count reduction of L still terminates.
    if (s == filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q >= filt_len_i) begin
      filt_d = s;
      fcnt_d = '0;
    end else begin
      fcnt_d = fcnt_q + FILT_W'(1);
    end

    rise_d = filt_d & ~filt_q;
    fall_d = ~filt_d & filt_q;

    // A qualified event beats a same-cycle clear and restarts the count at 1.
    if (qual) begin
      flag_d = 1'b1;
      if (clr_i) begin
        ecnt_d = CNT_W'(1);
      end else if (ecnt_q != '1) begin
        ecnt_d = ecnt_q + CNT_W'(1);
      end
    end else if (clr_i) begin
      flag_d = 1'b0;
      ecnt_d = '0;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign flag_o = flag_q;
  assign cnt_o  = ecnt_q;

endmodule

// File: rtl/edge_event_det.sv
// Multi-channel filtered edge/event detector.
// Ports:
//   clk_in, rst_n            clock / async active-low reset
//   inpsig[CH]               asynchronous raw inputs
//   edge_sel                 event qualification for all channels
//   filt_len                 glitch-filter length L
//   evt_clr[CH]              per-channel flag/counter clear
//   cnt_sel                  counter read index
//   sig_rising/sig_falling   registered one-cycle edge pulses
//   evt_flag[CH], evt_any    sticky flags and their OR
//   cnt_out                  selected counter (combinational, 0 if out of range)
module edge_event_det
  import edge_det_pkg::*;
#(
  parameter int unsigned CH          = CH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned FILT_W      = FILT_W_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic                                 clk_in,
  input  logic                                 rst_n,
  input  logic [CH-1:0]                        inpsig,
  input  logic [1:0]                           edge_sel,
  input  logic [FILT_W-1:0]                    filt_len,
  input  logic [CH-1:0]                        evt_clr,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cnt_sel,
  output logic [CH-1:0]                        sig_rising,
  output logic [CH-1:0]                        sig_falling,
  output logic [CH-1:0]                        evt_flag,
  output logic                                 evt_any,
  output logic [CNT_W-1:0]                     cnt_out
);

  localparam int unsigned SEL_W = (CH > 1) ? $clog2(CH) : 1;

  logic [CNT_W-1:0] cnt_arr [CH];

  for (genvar g = 0; g < CH; g++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_W     (FILT_W),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .raw_i     (inpsig[g]),
      .edge_sel_i(edge_sel),
      .filt_len_i(filt_len),
      .clr_i     (evt_clr[g]),
      .rise_o    (sig_rising[g]),
      .fall_o    (sig_falling[g]),
      .flag_o    (evt_flag[g]),
      .cnt_o     (cnt_arr[g])
    );
  end

  assign evt_any = |evt_flag;

  // Counter read mux; indices with no channel fall through to 0.
  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < int'(CH); i++) begin
      if (cnt_sel == SEL_W'(i)) cnt_out = cnt_arr[i];
    end
  end

endmodule

// File: tb/tb_edge_event_det.sv
// Directed self-checking bench for edge_event_det (default parameters).
module tb_edge_event_det;

  logic       clk_in;
  logic       rst_n;
  logic [7:0] inpsig;
  logic [1:0] edge_sel;
  logic [3:0] filt_len;
  logic [7:0] evt_clr;
  logic [2:0] cnt_sel;
  logic [7:0] sig_rising;
  logic [7:0] sig_falling;
  logic [7:0] evt_flag;
  logic       evt_any;
  logic [7:0] cnt_out;

  int tests;
  int fails;
  int nr;
  int nf;
  int np;
  logic [7:0] seen;

  edge_event_det dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .inpsig     (inpsig),
    .edge_sel   (edge_sel),
    .filt_len   (filt_len),
    .evt_clr    (evt_clr),
    .cnt_sel    (cnt_sel),
    .sig_rising (sig_rising),
    .sig_falling(sig_falling),
    .evt_flag   (evt_flag),
    .evt_any    (evt_any),
    .cnt_out    (cnt_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    inpsig   = 8'h00;
    edge_sel = 2'b01;
    filt_len = 4'd3;
    evt_clr  = 8'h00;
    cnt_sel  = 3'd0;

    // Reset state
    step(2);
    check("reset_rise", 32'(sig_rising), 32'h0);
    check("reset_flag", 32'(evt_flag), 32'h0);
    check("reset_any", 32'(evt_any), 32'h0);
    check("reset_cnt", 32'(cnt_out), 32'h0);
    rst_n = 1'b1;
    step(3);

    // Filtered rise on ch0, L=3: pulse after edge 6
    inpsig[0] = 1'b1;
    step(5);
    check("a_rise_e5", 32'(sig_rising), 32'h00);
    step(1);
    check("a_rise_e6", 32'(sig_rising), 32'h01);
    check("a_fall_e6", 32'(sig_falling), 32'h00);
    step(1);
    check("a_rise_e7", 32'(sig_rising), 32'h00);
    check("a_flag", 32'(evt_flag), 32'h01);
    check("a_any", 32'(evt_any), 32'h1);
    check("a_cnt0", 32'(cnt_out), 32'h1);
    cnt_sel = 3'd1;
    #1;
    check("a_cnt1", 32'(cnt_out), 32'h0);
    cnt_sel = 3'd0;
    // Falling edge is not qualified with rise-only selection
    inpsig[0] = 1'b0;
    step(6);
    check("a_fall_pulse", 32'(sig_falling), 32'h01);
    step(1);
    check("a_cnt_after_fall", 32'(cnt_out), 32'h1);
    evt_clr = 8'h01;
    step(1);
    evt_clr = 8'h00;
    check("a_clr_flag", 32'(evt_flag), 32'h00);
    check("a_clr_cnt", 32'(cnt_out), 32'h0);

    // Glitch of 3 cycles on ch2 is discarded
    inpsig[2] = 1'b1;
    step(3);
    inpsig[2] = 1'b0;
    seen = 8'h00;
    for (int i = 0; i < 10; i++) begin
      step(1);
      seen = seen | sig_rising | sig_falling;
    end
    check("b_glitch_pulses", 32'(seen), 32'h00);
    check("b_glitch_flag", 32'(evt_flag), 32'h00);
    cnt_sel = 3'd2;
    #1;
    check("b_glitch_cnt", 32'(cnt_out), 32'h0);
    // 4-cycle pulse passes: one rise, one fall
    inpsig[2] = 1'b1;
    step(4);
    inpsig[2] = 1'b0;
    nr = 0;
    nf = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      nr += int'(sig_rising[2]);
      nf += int'(sig_falling[2]);
    end
    check("b_rise_count", 32'(nr), 32'd1);
    check("b_fall_count", 32'(nf), 32'd1);
    check("b_flag", 32'(evt_flag), 32'h04);
    check("b_cnt", 32'(cnt_out), 32'h1);

    // Saturation on ch1: 300 filtered toggles, both edges qualified
    edge_sel = 2'b11;
    filt_len = 4'd0;
    cnt_sel  = 3'd1;
    np = 0;
    for (int i = 0; i < 300; i++) begin
      inpsig[1] = ~inpsig[1];
      step(1);
      np += int'(sig_rising[1]) + int'(sig_falling[1]);
      step(1);
      np += int'(sig_rising[1]) + int'(sig_falling[1]);
    end
    for (int i = 0; i < 6; i++) begin
      step(1);
      np += int'(sig_rising[1]) + int'(sig_falling[1]);
    end
    check("c_pulses", 32'(np), 32'd300);
    check("c_sat", 32'(cnt_out), 32'd255);
    check("c_flag", 32'(evt_flag[1]), 32'h1);
    inpsig[1] = 1'b1;
    step(2);
    inpsig[1] = 1'b0;
    step(6);
    check("c_sat_hold", 32'(cnt_out), 32'd255);
    evt_clr = 8'h02;
    step(1);
    evt_clr = 8'h00;
    check("c_clr_cnt", 32'(cnt_out), 32'd0);
    check("c_clr_flag", 32'(evt_flag[1]), 32'h0);

    // Clear/event collision on ch3 with fall-only selection
    edge_sel = 2'b10;
    cnt_sel  = 3'd3;
    inpsig[3] = 1'b1;
    step(5);
    check("d_rise_unqual", 32'(evt_flag[3]), 32'h0);
    inpsig[3] = 1'b0;
    step(5);
    check("d_first_cnt", 32'(cnt_out), 32'h1);
    inpsig[3] = 1'b1;
    step(5);
    inpsig[3] = 1'b0;
    step(3);
    check("d_fall_pulse", 32'(sig_falling), 32'h08);
    evt_clr = 8'h08;
    step(1);
    evt_clr = 8'h00;
    check("d_coll_flag", 32'(evt_flag[3]), 32'h1);
    check("d_coll_cnt", 32'(cnt_out), 32'h1);

    // All channels rise together, L=0
    evt_clr = 8'hFF;
    step(1);
    evt_clr = 8'h00;
    check("e_clr_flags", 32'(evt_flag), 32'h00);
    check("e_clr_any", 32'(evt_any), 32'h0);
    edge_sel = 2'b01;
    inpsig   = 8'hFF;
    step(2);
    check("e_rise_e2", 32'(sig_rising), 32'h00);
    step(1);
    check("e_rise_e3", 32'(sig_rising), 32'hFF);
    step(1);
    check("e_flags", 32'(evt_flag), 32'hFF);
    check("e_any", 32'(evt_any), 32'h1);
    for (int i = 0; i < 8; i++) begin
      cnt_sel = 3'(i);
      #1;
      check($sformatf("e_cnt%0d", i), 32'(cnt_out), 32'h1);
    end

    // Reset during a pending filter count
    filt_len = 4'd3;
    inpsig   = 8'h00;
    step(10);
    check("f_flags_pre", 32'(evt_flag), 32'hFF);
    inpsig = 8'hFF;
    step(4);
    rst_n = 1'b0;
    #1;
    check("f_rst_rise", 32'(sig_rising), 32'h00);
    check("f_rst_fall", 32'(sig_falling), 32'h00);
    check("f_rst_flag", 32'(evt_flag), 32'h00);
    check("f_rst_any", 32'(evt_any), 32'h0);
    check("f_rst_cnt", 32'(cnt_out), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(5);
    check("f_rise_e5", 32'(sig_rising), 32'h00);
    step(1);
    check("f_rise_e6", 32'(sig_rising), 32'hFF);
    step(1);
    check("f_rise_e7", 32'(sig_rising), 32'h00);
    check("f_flags_post", 32'(evt_flag), 32'hFF);
    nr = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      nr += int'(sig_rising[0]);
    end
    check("f_no_extra", 32'(nr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
